// File: rtl/mbc_port_scheduler.sv
// mbc_port_scheduler: per-port request FIFOs with tagging, freeze replay, response registering and in-flight tracking
module mbc_port_scheduler #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [11:0] req1_addr,
  input  logic [15:0] req1_data,
  input  logic        req1_wen,
  output logic [1:0]  req1_tag,
  input  logic        req2_valid,
  output logic        req2_ready,
  input  logic [11:0] req2_addr,
  input  logic [15:0] req2_data,
  input  logic        req2_wen,
  output logic [1:0]  req2_tag,
  input  logic        req3_valid,
  output logic        req3_ready,
  input  logic [11:0] req3_addr,
  input  logic [15:0] req3_data,
  input  logic        req3_wen,
  output logic [1:0]  req3_tag,
  output logic [1:0]  port1_req_tag_in,
  output logic [11:0] port1_addr,
  output logic [15:0] port1_data_in,
  output logic        port1_wen,
  output logic        port1_valid,
  output logic [1:0]  port2_req_tag_in,
  output logic [11:0] port2_addr,
  output logic [15:0] port2_data_in,
  output logic        port2_wen,
  output logic        port2_valid,
  output logic [1:0]  port3_req_tag_in,
  output logic [11:0] port3_addr,
  output logic [15:0] port3_data_in,
  output logic        port3_wen,
  output logic        port3_valid,
  input  logic        freeze_inputs,
  input  logic [1:0]  port1_req_tag_out,
  input  logic [15:0] port1_data_out,
  input  logic        port1_valid_out,
  input  logic [1:0]  port2_req_tag_out,
  input  logic [15:0] port2_data_out,
  input  logic        port2_valid_out,
  input  logic [1:0]  port3_req_tag_out,
  input  logic [15:0] port3_data_out,
  input  logic        port3_valid_out,
  output logic        rsp1_valid,
  output logic [1:0]  rsp1_tag,
  output logic [15:0] rsp1_data,
  output logic        rsp2_valid,
  output logic [1:0]  rsp2_tag,
  output logic [15:0] rsp2_data,
  output logic        rsp3_valid,
  output logic [1:0]  rsp3_tag,
  output logic [15:0] rsp3_data,
  input  logic        drain,
  output logic        idle,
  output logic        err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0] MAX_V = 3'(MAX_OUTSTANDING);
  logic [2:0]  valid_in, wen_in, ready, empty, busy, spur, cl_valid;
  logic [2:0]  rsp_v;
  logic [11:0] addr_in [3];
  logic [15:0] data_in [3];
  logic [1:0]  cl_tag [3];
  logic [15:0] cl_data [3];
  logic [1:0]  tag_cnt [3];
  logic [30:0] head [3];
  logic [17:0] rsp_r [3];
  assign valid_in = {req3_valid, req2_valid, req1_valid};
  assign wen_in   = {req3_wen, req2_wen, req1_wen};
  assign cl_valid = {port3_valid_out, port2_valid_out, port1_valid_out};
  assign addr_in  = '{req1_addr, req2_addr, req3_addr};
  assign data_in  = '{req1_data, req2_data, req3_data};
  assign cl_tag   = '{port1_req_tag_out, port2_req_tag_out, port3_req_tag_out};
  assign cl_data  = '{port1_data_out, port2_data_out, port3_data_out};
  for (genvar i = 0; i < 3; i++) begin : g_port
    logic [30:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [2:0]  inflight;
    logic        full, push, pop, dec;
    always_comb begin
      empty[i] = wr_ptr == rd_ptr;
      full     = (wr_ptr - rd_ptr) == DEPTH_V;
      ready[i] = !reset && !drain && !full && inflight < MAX_V;
      push     = valid_in[i] && ready[i];
      pop      = !empty[i] && !freeze_inputs;
      spur[i]  = cl_valid[i] && inflight == 3'd0;
      dec      = cl_valid[i] && !spur[i];
      busy[i]  = !empty[i] || inflight != 3'd0;
      head[i]  = empty[i] ? '0 : mem[rd_ptr[AW-1:0]];
    end
    always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= {tag_cnt[i], addr_in[i], data_in[i], wen_in[i]};
    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        tag_cnt[i] <= '0;
        inflight   <= '0;
        rsp_v[i]   <= 1'b0;
        rsp_r[i]   <= '0;
      end else begin
        wr_ptr     <= wr_ptr + (AW+1)'(push);
        rd_ptr     <= rd_ptr + (AW+1)'(pop);
        tag_cnt[i] <= tag_cnt[i] + 2'(push);
        inflight   <= inflight + 3'(push) - 3'(dec);
        rsp_v[i]   <= cl_valid[i];
        rsp_r[i]   <= cl_valid[i] ? {cl_tag[i], cl_data[i]} : '0;
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) err <= 1'b0;
    else if (|spur) err <= 1'b1;
  assign idle = ~|busy;
  assign {req3_ready, req2_ready, req1_ready} = ready;
  assign req1_tag = tag_cnt[0];
  assign req2_tag = tag_cnt[1];
  assign req3_tag = tag_cnt[2];
  assign {port1_req_tag_in, port1_addr, port1_data_in, port1_wen} = head[0];
  assign {port2_req_tag_in, port2_addr, port2_data_in, port2_wen} = head[1];
  assign {port3_req_tag_in, port3_addr, port3_data_in, port3_wen} = head[2];
  assign {port3_valid, port2_valid, port1_valid} = ~empty;
  assign {rsp3_valid, rsp2_valid, rsp1_valid} = rsp_v;
  assign {rsp1_tag, rsp1_data} = rsp_r[0];
  assign {rsp2_tag, rsp2_data} = rsp_r[1];
  assign {rsp3_tag, rsp3_data} = rsp_r[2];
endmodule

// File: doc/mbc_port_scheduler.md
# mbc_port_scheduler

Front-end scheduler for the three-port, four-bank memory cluster. It accepts requests from three independent requesters through valid/ready handshakes and buffers each port in its own FIFO. It assigns each request a 2-bit tag and presents the FIFO heads to the cluster, replaying any request the cluster drops while `freeze_inputs` is high. Cluster responses return to the originating requester through a registered stage, and the block tracks in-flight requests for drain/idle sequencing.

## Interface
- `FIFO_DEPTH`, default 4: entries per port FIFO; power of two, ≥2.
- `MAX_OUTSTANDING`, default 4: per-port limit on requests enqueued but not yet responded; range 1..4.

Ports (N = 1, 2, 3):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `reqN_valid` in 1: requester offers a request.
- `reqN_ready` out 1: scheduler accepts the request this cycle.
- `reqN_addr` in 12: request address.
- `reqN_data` in 16: write data.
- `reqN_wen` in 1: 1 = write, 0 = read.
- `reqN_tag` out 2: tag that the next accepted request on port N receives.
- `portN_req_tag_in` out 2: tag of the FIFO head, driven to the cluster.
- `portN_addr` out 12: address of the FIFO head, driven to the cluster.
- `portN_data_in` out 16: write data of the FIFO head, driven to the cluster.
- `portN_wen` out 1: write enable of the FIFO head, driven to the cluster.
- `portN_valid` out 1: FIFO head valid, driven to the cluster.
- `freeze_inputs` in 1: cluster is masking its inputs this cycle.
- `portN_req_tag_out` in 2: cluster response tag.
- `portN_data_out` in 16: cluster response data.
- `portN_valid_out` in 1: cluster response valid.
- `rspN_valid` out 1: registered response to requester.
- `rspN_tag` out 2: registered response tag.
- `rspN_data` out 16: registered response data.
- `drain` in 1: stop accepting new requests.
- `idle` out 1: all FIFOs empty and no requests in flight.
- `err` out 1: sticky flag; a response arrived on a port with zero in-flight requests.

## Operation
- Per-port state:
  - FIFO of {tag, addr, data, wen} with `FIFO_DEPTH` entries.
  - 2-bit tag counter.
  - In-flight counter, 0..`MAX_OUTSTANDING`; counts requests from enqueue until response.
- Accept condition: `reqN_ready` = !reset & !drain & FIFO not full & inflightN < `MAX_OUTSTANDING`.
- Enqueue occurs when `reqN_valid` & `reqN_ready`:
  - Entry stores the current tag.
  - Tag counter increments modulo 4.
  - inflightN increments.
- Tag uniqueness: `MAX_OUTSTANDING` ≤ 4, so live tags on a port are unique.
- Issue: `portN_valid` = FIFO not empty. `portN_*` outputs carry the head entry; all are zero when the FIFO is empty.
- Pop condition: FIFO not empty & !`freeze_inputs`. The cluster captures the request in that cycle. While freeze is high the head is held unchanged and re-presented every cycle.
- The cluster returns exactly one `portN_valid_out` pulse per captured request, reads and writes alike. Responses may arrive in any order across tags.
- On `portN_valid_out`:
  - inflightN decrements.
  - Next cycle, `rspN_valid`=1 with `rspN_tag`/`rspN_data` equal to the cluster values. These outputs are zero when no response is pending.
- Simultaneous enqueue and response on one port: inflightN is unchanged.
- Response with inflightN = 0: the counter stays 0 and `err` sets; `err` holds until reset.
- Full FIFO: no same-cycle bypass. `reqN_ready` is 0 even when a pop occurs that cycle.
- Empty FIFO: no bypass. A request enqueued in cycle t is first presented to the cluster in t+1.
- `idle` = all FIFOs empty & all inflight = 0. It is combinational from registered state.
- `drain` only blocks acceptance. Queued entries still issue and responses still return. `idle` rises once everything completes.
- Ports are fully independent; no cross-port arbitration inside this block.

## Timing
- Reset (synchronous, sampled at the rising edge) clears FIFOs, tag counters, inflight counters, rsp registers and `err`.
- Output values after reset:
  - `reqN_ready`=0 while `reset` is high; it is 1 the cycle after deassertion unless `drain` is high.
  - `reqN_tag`=0, `portN_*`=0, `rspN_*`=0, `err`=0, `idle`=1.
- Reset mid-operation discards queued and in-flight requests. Any cluster responses arriving later are treated as spurious and set `err`; the integrator must reset the cluster together with this block.
- Latency, with no freeze and an empty FIFO:
  - Enqueue edge t.
  - Presented to the cluster in t+1 and popped at the end of t+1.
  - Cluster response in cycle r gives `rspN_valid` in r+1.
- Each freeze cycle adds exactly one cycle of issue delay per port.
- Throughput: one enqueue and one pop per port per cycle.

## Test plan
- Single read on port 1: reset, then addr 0x005 with wen=0. `port1_valid`=1 with tag 0 one cycle after the handshake. A cluster response of tag 0, data 0xBEEF gives `rsp1_valid`, `rsp1_tag`=0, `rsp1_data`=0xBEEF one cycle later. `idle` returns to 1.
- Freeze replay: hold `freeze_inputs`=1 for 3 cycles with port 2 holding addr 0x7FF. `port2_*` stays stable for those 3 cycles. The pop occurs on the first freeze-low cycle, and exactly one request is issued.
- Outstanding limit: `MAX_OUTSTANDING`=4, 5 back-to-back requests on port 3 with no responses. Tags 0,1,2,3 are assigned and `req3_ready` drops after the 4th. A response for tag 2 re-enables ready, and the 5th request receives tag 0.
- FIFO full: `FIFO_DEPTH`=2 with freeze held high, on a port with inflight below the limit. `reqN_ready` drops after 2 accepts and stays 0 until freeze falls and a pop completes.
- Drain with simultaneous events: assert `drain` while 2 requests are queued, making an enqueue and a response coincide on one port in the prior cycle. Inflight is correct, ready is 0, and `idle` rises only after both responses.
- Spurious response: `port1_valid_out`=1 right after reset. `err`=1 and stays set, inflight1 stays 0, and a later reset clears `err`.
